distance_argmin: RTL and testbench
==================================

DISTANCE_ARGMIN -- requirements
Module: distance_argmin

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- DATA_W, 64: accumulated-distance width.
- WORD_W, 4: vocabulary word-index width.
- NUM_WORDS, 16: expected candidates per utterance.
REQ-002 The block SHALL have one clock, iclk, and one reset, irst; reset is synchronous and active-high.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- iclk, in, 1: clock.
- irst, in, 1: synchronous active-high reset.
- idata, in, DATA_W: final accumulated distance for one candidate word.
- iword, in, WORD_W: word index of that candidate.
- ivalid, in, 1: candidate beat valid.
- ilast, in, 1: beat is the last candidate of the utterance.
- oready, out, 1: block accepts candidate beats.
- odata, out, DATA_W: smallest distance.
- oword, out, WORD_W: word index of the smallest distance.
- omargin, out, DATA_W: second-smallest minus smallest distance.
- ocount, out, WORD_W+1: candidates accepted this utterance.
- ooverflow, out, 1: more than NUM_WORDS candidates were accepted.
- ovalid, out, 1: result valid.
- iready, in, 1: downstream accepts the result.

Function
REQ-004 A beat SHALL be accepted only on a rising edge of iclk where ivalid=1 and oready=1; idata, iword and ilast are sampled on that edge.
REQ-005 The state machine SHALL have three states: S_IDLE, S_COLLECT and S_DONE.
REQ-006 oready SHALL be 1 in S_IDLE and S_COLLECT and 0 in S_DONE.
REQ-007 ovalid SHALL be 1 exactly while in S_DONE.
REQ-008 On a beat accepted in S_IDLE, the block SHALL load: best=idata, best_word=iword, second=all-ones, count=1, overflow=0.
REQ-009 After an S_IDLE beat, the next state SHALL be S_DONE if ilast=1, else S_COLLECT.
REQ-010 On a beat accepted in S_COLLECT, the block SHALL update the top-two tracker:
- idata < best: second<=best, best<=idata, best_word<=iword.
- else if idata < second: second<=idata.
- else: no change to best or second.
REQ-011 Ties SHALL keep the earlier best_word; idata == best SHALL set second<=idata, giving margin 0.
REQ-012 Each S_COLLECT beat SHALL increment count, saturating at 2^(WORD_W+1)-1.
REQ-013 If an S_COLLECT beat is accepted while count==NUM_WORDS, overflow SHALL be set; the beat is still compared.
REQ-014 An S_COLLECT beat with ilast=1 SHALL move the state to S_DONE.
REQ-015 Latency: ovalid SHALL assert on the cycle immediately after the ilast beat is accepted.
REQ-016 In S_DONE, odata, oword, omargin, ocount and ooverflow SHALL hold stable.
REQ-017 In S_DONE, ivalid SHALL be ignored and SHALL cause no state change.
REQ-018 S_DONE with iready=1 on an edge SHALL go to S_IDLE, with ovalid=0 the next cycle. iready while not in S_DONE has no effect.
REQ-019 omargin SHALL be all-ones when second is all-ones (single candidate); otherwise it SHALL be second-best, which is never negative.
REQ-020 Duplicate iword values SHALL NOT be checked; each beat is a distinct candidate.
REQ-021 Distances SHALL be compared as unsigned DATA_W values.
REQ-022 Outside S_DONE, the outputs SHALL show the live tracker registers; downstream uses them only when ovalid=1.

Reset
REQ-023 irst=1 on an edge SHALL force S_IDLE and clear all outputs: odata=0, oword=0, omargin=0, ocount=0, ooverflow=0, ovalid=0. oready=1 from the next cycle.
REQ-024 Reset SHALL take priority over any simultaneous beat or iready; reset mid-utterance or in S_DONE discards the partial or held result.

Structure
REQ-025 A shared package distance_pkg SHALL hold the state-encoding typedef and the DATA_W/WORD_W defaults, shared with the distance-accumulator stage.
REQ-026 The comparison of REQ-010/011 SHALL be one sub-module, top2_tracker: purely combinational next-best/next-second/next-word logic. The registers and FSM stay in distance_argmin.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
- V1: beats (w0,500),(w1,120),(w2,300,last) -> ovalid next cycle; oword=1, odata=120, omargin=180, ocount=3, ooverflow=0.
- V2: single beat (w7,42,last) -> oword=7, odata=42, omargin=all-ones, ocount=1.
- V3 (tie): (w3,100),(w5,100,last) -> oword=3, omargin=0.
- V4: 17 beats, distances 17..1, last on beat 17 -> ooverflow=1, ocount=17, oword of the distance-1 beat, omargin=1.
- V5 (backpressure): hold iready=0 for 5 cycles in S_DONE while driving ivalid=1 -> oready=0, outputs stable, no beat consumed. Then iready=1 -> S_IDLE; the next utterance is correct.
- V6 (reset mid-utterance): irst=1 after 2 beats of 4 -> all outputs zero. A new 2-beat utterance then reports only its own min and ocount=2.

Source files
------------

// File: rtl/distance_pkg.sv
// Shared types and width defaults for the distance-accumulator and argmin stages.
package distance_pkg;

    localparam int unsigned DATA_W_DEF = 64;
    localparam int unsigned WORD_W_DEF = 4;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DONE    = 2'd2
    } state_e;

endpackage

// File: rtl/top2_tracker.sv
// Combinational top-two tracker: folds one candidate distance into (best, second, best word).
module top2_tracker #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned WORD_W = 4
) (
    input  logic [DATA_W-1:0] best_i,
    input  logic [DATA_W-1:0] second_i,
    input  logic [WORD_W-1:0] word_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [WORD_W-1:0] dword_i,
    output logic [DATA_W-1:0] best_o,
    output logic [DATA_W-1:0] second_o,
    output logic [WORD_W-1:0] word_o
);

    always_comb begin
        best_o   = best_i;
        second_o = second_i;
        word_o   = word_i;
        if (data_i < best_i) begin
            second_o = best_i;
            best_o   = data_i;
            word_o   = dword_i;
        end else if (data_i < second_i) begin
            // Equal-to-best lands here, so a tie keeps the earlier word with zero margin.
            second_o = data_i;
        end
    end

endmodule

// File: rtl/distance_argmin.sv
// Picks the smallest accumulated distance over an utterance of candidate words and
// reports its word index, the margin to the runner-up and the candidate count.
module distance_argmin
    import distance_pkg::*;
#(
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned WORD_W    = WORD_W_DEF,
    parameter int unsigned NUM_WORDS = 16
) (
    input  logic              iclk,
    input  logic              irst,
    input  logic [DATA_W-1:0] idata,
    input  logic [WORD_W-1:0] iword,
    input  logic              ivalid,
    input  logic              ilast,
    output logic              oready,
    output logic [DATA_W-1:0] odata,
    output logic [WORD_W-1:0] oword,
    output logic [DATA_W-1:0] omargin,
    output logic [WORD_W:0]   ocount,
    output logic              ooverflow,
    output logic              ovalid,
    input  logic              iready
);

    localparam int unsigned CNT_W = WORD_W + 1;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] best_q, best_d;
    logic [DATA_W-1:0] second_q, second_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d;

    logic [DATA_W-1:0] trk_best, trk_second;
    logic [WORD_W-1:0] trk_word;

    top2_tracker #(
        .DATA_W (DATA_W),
        .WORD_W (WORD_W)
    ) u_tracker (
        .best_i   (best_q),
        .second_i (second_q),
        .word_i   (word_q),
        .data_i   (idata),
        .dword_i  (iword),
        .best_o   (trk_best),
        .second_o (trk_second),
        .word_o   (trk_word)
    );

    always_comb begin
        state_d  = state_q;
        best_d   = best_q;
        second_d = second_q;
        word_d   = word_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        unique case (state_q)
            S_IDLE: begin
                if (ivalid) begin
                    best_d   = idata;
                    word_d   = iword;
                    second_d = '1;
                    count_d  = CNT_W'(1);
                    ovf_d    = 1'b0;
                    state_d  = ilast ? S_DONE : S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (ivalid) begin
                    best_d   = trk_best;
                    second_d = trk_second;
                    word_d   = trk_word;
                    count_d  = (count_q == '1) ? count_q : count_q + CNT_W'(1);
                    if (count_q == CNT_W'(NUM_WORDS)) begin
                        ovf_d = 1'b1;
                    end
                    if (ilast) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                // Result held; incoming beats are refused via oready.
                if (iready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge iclk) begin
        if (irst) begin
            state_q  <= S_IDLE;
            best_q   <= '0;
            second_q <= '0;
            word_q   <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            best_q   <= best_d;
            second_q <= second_d;
            word_q   <= word_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    assign oready    = (state_q != S_DONE);
    assign ovalid    = (state_q == S_DONE);
    assign odata     = best_q;
    assign oword     = word_q;
    // An all-ones runner-up means only one candidate was seen.
    assign omargin   = (second_q == '1) ? '1 : second_q - best_q;
    assign ocount    = count_q;
    assign ooverflow = ovf_q;

endmodule

// File: tb/tb_distance_argmin.sv
// Scoreboard bench for distance_argmin: directed utterances plus a randomised back-to-back run.
module tb_distance_argmin;

    localparam int unsigned DW = 64;
    localparam int unsigned WW = 4;
    localparam logic [DW-1:0] ONES = '1;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [WW-1:0] word;
        logic [DW-1:0] margin;
        logic [WW:0]   count;
        logic          ovf;
    } res_t;

    logic          iclk = 1'b0;
    logic          irst = 1'b1;
    logic [DW-1:0] idata = '0;
    logic [WW-1:0] iword = '0;
    logic          ivalid = 1'b0;
    logic          ilast = 1'b0;
    logic          iready = 1'b0;
    logic          oready;
    logic [DW-1:0] odata;
    logic [WW-1:0] oword;
    logic [DW-1:0] omargin;
    logic [WW:0]   ocount;
    logic          ooverflow;
    logic          ovalid;

    int n_vec = 0;
    int n_err = 0;

    res_t          sb[$];
    logic [DW-1:0] bd[$];
    logic [WW-1:0] bw[$];

    distance_argmin #(
        .DATA_W    (DW),
        .WORD_W    (WW),
        .NUM_WORDS (16)
    ) dut (
        .iclk      (iclk),
        .irst      (irst),
        .idata     (idata),
        .iword     (iword),
        .ivalid    (ivalid),
        .ilast     (ilast),
        .oready    (oready),
        .odata     (odata),
        .oword     (oword),
        .omargin   (omargin),
        .ocount    (ocount),
        .ooverflow (ooverflow),
        .ovalid    (ovalid),
        .iready    (iready)
    );

    always #5 iclk = ~iclk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation still running, required completion");
        $fatal(1, "timeout");
    end

    // Drives the beats in bd/bw, one per cycle; called and returns at a negedge.
    task automatic drive_beats(input bit mark_last);
        foreach (bd[i]) begin
            ivalid = 1'b1;
            idata  = bd[i];
            iword  = bw[i];
            ilast  = mark_last && (i == bd.size() - 1);
            @(negedge iclk);
        end
        ivalid = 1'b0;
        ilast  = 1'b0;
    endtask

    // Bounded wait for ovalid; lat counts the extra cycles needed beyond the first sample.
    task automatic wait_result(output res_t got, output bit ok, output int lat);
        ok  = 1'b0;
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            if (ovalid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge iclk);
            lat++;
        end
        got = {odata, oword, omargin, ocount, ooverflow};
    endtask

    task automatic release_result();
        iready = 1'b1;
        @(negedge iclk);
        iready = 1'b0;
    endtask

    // Reference built independently of the streaming tracker: earliest global minimum,
    // runner-up as the minimum over every other beat.
    function automatic res_t model();
        res_t r;
        int bi = 0;
        logic [DW-1:0] sec = ONES;
        int n = bd.size();
        foreach (bd[i]) if (bd[i] < bd[bi]) bi = i;
        foreach (bd[j]) if (j != bi && bd[j] < sec) sec = bd[j];
        r.data   = bd[bi];
        r.word   = bw[bi];
        r.margin = (sec == ONES) ? ONES : sec - bd[bi];
        r.count  = (n > 31) ? 5'd31 : 5'(n);
        r.ovf    = (n > 16);
        return r;
    endfunction

    task automatic test_reset();
        irst   = 1'b1;
        ivalid = 1'b1;
        ilast  = 1'b1;
        iready = 1'b1;
        idata  = 64'd9;
        iword  = 4'd9;
        @(negedge iclk);
        @(negedge iclk);
        irst   = 1'b0;
        ivalid = 1'b0;
        ilast  = 1'b0;
        iready = 1'b0;
        n_vec++;
        if ({odata, oword, omargin, ocount, ooverflow, ovalid, oready} !== {138'd0, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL reset_outputs: got data=%0h word=%0d margin=%0h count=%0d ovf=%0b valid=%0b ready=%0b required all zero, ready=1",
                     odata, oword, omargin, ocount, ooverflow, ovalid, oready);
        end
    endtask

    task automatic test_basic();
        res_t got, exp;
        bit ok;
        int lat;
        bd = '{64'd500, 64'd120, 64'd300};
        bw = '{4'd0, 4'd1, 4'd2};
        sb.push_back({64'd120, 4'd1, 64'd180, 5'd3, 1'b0});
        drive_beats(1'b1);
        wait_result(got, ok, lat);
        n_vec++;
        if (!ok || lat != 0) begin
            n_err++;
            $display("FAIL v1_latency: got valid=%0b after %0d extra cycles, required valid=1 after 0", ok, lat);
        end
        exp = sb.pop_front();
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL v1_result: got %h required %h", got, exp);
        end
        release_result();
        n_vec++;
        if (ovalid !== 1'b0 || oready !== 1'b1) begin
            n_err++;
            $display("FAIL v1_release: got valid=%0b ready=%0b required valid=0 ready=1", ovalid, oready);
        end
    endtask

    task automatic test_single();
        res_t got, exp;
        bit ok;
        int lat;
        bd = '{64'd42};
        bw = '{4'd7};
        sb.push_back({64'd42, 4'd7, ONES, 5'd1, 1'b0});
        drive_beats(1'b1);
        wait_result(got, ok, lat);
        exp = sb.pop_front();
        n_vec++;
        if (!ok || got !== exp) begin
            n_err++;
            $display("FAIL v2_single: got valid=%0b %h required %h", ok, got, exp);
        end
        release_result();
    endtask

    task automatic test_tie();
        res_t got, exp;
        bit ok;
        int lat;
        bd = '{64'd100, 64'd100};
        bw = '{4'd3, 4'd5};
        sb.push_back({64'd100, 4'd3, 64'd0, 5'd2, 1'b0});
        drive_beats(1'b1);
        wait_result(got, ok, lat);
        exp = sb.pop_front();
        n_vec++;
        if (!ok || got !== exp) begin
            n_err++;
            $display("FAIL v3_tie: got valid=%0b %h required %h", ok, got, exp);
        end
        release_result();
    endtask

    task automatic test_overflow();
        res_t got, exp;
        bit ok;
        int lat;
        bd.delete();
        bw.delete();
        for (int i = 0; i < 17; i++) begin
            bd.push_back(64'(17 - i));
            bw.push_back(4'((i + 3) % 16));
        end
        // Distance 1 is beat 17, word (16+3)%16 = 3; runner-up is 2.
        sb.push_back({64'd1, 4'd3, 64'd1, 5'd17, 1'b1});
        drive_beats(1'b1);
        wait_result(got, ok, lat);
        exp = sb.pop_front();
        n_vec++;
        if (!ok || got !== exp) begin
            n_err++;
            $display("FAIL v4_overflow: got valid=%0b %h required %h", ok, got, exp);
        end
        release_result();
    endtask

    task automatic test_backpressure();
        res_t got, exp;
        bit ok;
        int lat;
        bd = '{64'd900, 64'd250, 64'd400};
        bw = '{4'd4, 4'd8, 4'd12};
        sb.push_back({64'd250, 4'd8, 64'd150, 5'd3, 1'b0});
        drive_beats(1'b1);
        wait_result(got, ok, lat);
        exp = sb.pop_front();
        n_vec++;
        if (!ok || got !== exp) begin
            n_err++;
            $display("FAIL v5_result: got valid=%0b %h required %h", ok, got, exp);
        end
        ivalid = 1'b1;
        ilast  = 1'b1;
        idata  = 64'd0;
        iword  = 4'd15;
        for (int c = 0; c < 5; c++) begin
            @(negedge iclk);
            got = {odata, oword, omargin, ocount, ooverflow};
            n_vec++;
            if (oready !== 1'b0 || ovalid !== 1'b1 || got !== exp) begin
                n_err++;
                $display("FAIL v5_hold_c%0d: got ready=%0b valid=%0b %h required ready=0 valid=1 %h",
                         c, oready, ovalid, got, exp);
            end
        end
        ivalid = 1'b0;
        ilast  = 1'b0;
        release_result();
        n_vec++;
        if (ovalid !== 1'b0 || oready !== 1'b1) begin
            n_err++;
            $display("FAIL v5_release: got valid=%0b ready=%0b required valid=0 ready=1", ovalid, oready);
        end
        bd = '{64'd10, 64'd5};
        bw = '{4'd2, 4'd4};
        sb.push_back({64'd5, 4'd4, 64'd5, 5'd2, 1'b0});
        drive_beats(1'b1);
        wait_result(got, ok, lat);
        exp = sb.pop_front();
        n_vec++;
        if (!ok || got !== exp) begin
            n_err++;
            $display("FAIL v5_next: got valid=%0b %h required %h", ok, got, exp);
        end
        release_result();
    endtask

    task automatic test_reset_mid();
        res_t got, exp;
        bit ok;
        int lat;
        bd = '{64'd5, 64'd7};
        bw = '{4'd1, 4'd2};
        drive_beats(1'b0);
        irst = 1'b1;
        @(negedge iclk);
        irst = 1'b0;
        n_vec++;
        if ({odata, oword, omargin, ocount, ooverflow, ovalid, oready} !== {138'd0, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL v6_reset: got data=%0h word=%0d margin=%0h count=%0d ovf=%0b valid=%0b ready=%0b required all zero, ready=1",
                     odata, oword, omargin, ocount, ooverflow, ovalid, oready);
        end
        bd = '{64'd50, 64'd60};
        bw = '{4'd6, 4'd8};
        sb.push_back({64'd50, 4'd6, 64'd10, 5'd2, 1'b0});
        drive_beats(1'b1);
        wait_result(got, ok, lat);
        exp = sb.pop_front();
        n_vec++;
        if (!ok || got !== exp) begin
            n_err++;
            $display("FAIL v6_after: got valid=%0b %h required %h", ok, got, exp);
        end
        release_result();
    endtask

    task automatic test_back_to_back();
        res_t got, exp;
        bit ok;
        int lat;
        for (int u = 0; u < 20; u++) begin
            int n = $urandom_range(1, 34);
            bd.delete();
            bw.delete();
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) == 0) bd.push_back({$urandom, $urandom});
                else                           bd.push_back(64'($urandom_range(0, 40)));
                bw.push_back(4'($urandom_range(0, 15)));
            end
            sb.push_back(model());
            drive_beats(1'b1);
            wait_result(got, ok, lat);
            exp = sb.pop_front();
            n_vec++;
            if (!ok || lat != 0 || got !== exp) begin
                n_err++;
                $display("FAIL rand_u%0d (n=%0d): got valid=%0b lat=%0d %h required lat=0 %h",
                         u, n, ok, lat, got, exp);
            end
            release_result();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_single();
        test_tie();
        test_overflow();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
